// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART TX report arbiter: FSM encodings and default sizes.
package uart_tx_arb_pkg;

  localparam int unsigned seq_dp_width     = 16;
  localparam int unsigned UART_ARB_NUM_REQ = 4;
  localparam int unsigned UART_ARB_RW      = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of i_pend at or above i_ptr, with wrap.
module uart_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = UART_ARB_NUM_REQ,
  localparam int unsigned IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_pend,
  input  logic [IW-1:0]      i_ptr,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  // Scan offsets from farthest to nearest so the nearest pending index wins.
  always_comb begin
    int          w_j;
    logic [IW-1:0] w_idx;
    o_idx   = i_ptr;
    o_valid = 1'b0;
    w_j     = 0;
    w_idx   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= int'(NUM_REQ)) begin
        w_j = w_j - int'(NUM_REQ);
      end
      w_idx = IW'(w_j);
      if (i_pend[w_idx]) begin
        o_idx   = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_top report path among NUM_REQ one-entry buffers.
// Optional per-requester saturating drop counters: define UART_TX_ARB_DROP_CNT_EN.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = UART_ARB_NUM_REQ,
  parameter int unsigned DW      = seq_dp_width,
  parameter int unsigned RW      = UART_ARB_RW,
  localparam int unsigned IW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    i_req_stb,
  input  logic [NUM_REQ*DW-1:0] i_req_data,
  input  logic [NUM_REQ*RW-1:0] i_req_reg,
  output logic [NUM_REQ-1:0]    o_req_pend,
  output logic [NUM_REQ-1:0]    o_req_drop,
  output logic [DW-1:0]         o_tx_data,
  output logic [RW-1:0]         o_tx_reg,
  output logic                  o_tx_stb,
  input  logic                  i_tx_busy,
`ifdef UART_TX_ARB_DROP_CNT_EN
  output logic [NUM_REQ*8-1:0]  o_drop_cnt,
`endif
  output logic [IW-1:0]         o_grant
);

  arb_state_e         r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_grant;
  logic [DW-1:0]      r_tx_data;
  logic [RW-1:0]      r_tx_reg;
  logic               r_tx_stb;
  logic [NUM_REQ-1:0] r_pend;
  logic [NUM_REQ-1:0] r_drop;
  logic [DW-1:0]      r_buf_data [NUM_REQ];
  logic [RW-1:0]      r_buf_reg  [NUM_REQ];

  logic [NUM_REQ-1:0] w_clr;
  logic [NUM_REQ-1:0] w_accept;
  logic [NUM_REQ-1:0] w_drop;
  logic [IW-1:0]      w_win;
  logic               w_win_vld;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_pend  (r_pend),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_win),
    .o_valid (w_win_vld)
  );

  // A strobe landing in its own ISSUE cycle re-arms the buffer instead of dropping.
  always_comb begin
    w_clr    = '0;
    w_accept = '0;
    w_drop   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_clr[k]    = (r_state == ST_ISSUE) && (r_grant == IW'(k));
      w_accept[k] = i_req_stb[k] && (!r_pend[k] || w_clr[k]);
      w_drop[k]   = i_req_stb[k] && r_pend[k] && !w_clr[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_drop <= '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        r_buf_data[k] <= '0;
        r_buf_reg[k]  <= '0;
      end
    end else begin
      r_drop <= w_drop;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (w_accept[k]) begin
          r_pend[k]     <= 1'b1;
          r_buf_data[k] <= i_req_data[k*DW +: DW];
          r_buf_reg[k]  <= i_req_reg[k*RW +: RW];
        end else if (w_clr[k]) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  // Tag/data/grant only change on IDLE exit: uart_top reads i_reg live while printing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_tx_data <= '0;
      r_tx_reg  <= '0;
      r_tx_stb  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_vld && !i_tx_busy) begin
            r_grant   <= w_win;
            r_tx_data <= r_buf_data[w_win];
            r_tx_reg  <= r_buf_reg[w_win];
            r_rr_ptr  <= (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            r_tx_stb  <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_tx_stb <= 1'b0;
          r_state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (i_tx_busy) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!i_tx_busy) r_state <= ST_IDLE;
        end
        default: begin
          r_tx_stb <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_pend = r_pend;
  assign o_req_drop = r_drop;
  assign o_tx_data  = r_tx_data;
  assign o_tx_reg   = r_tx_reg;
  assign o_tx_stb   = r_tx_stb;
  assign o_grant    = r_grant;

`ifdef UART_TX_ARB_DROP_CNT_EN
  logic [7:0] r_drop_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_REQ); k++) r_drop_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        if (w_drop[k] && (r_drop_cnt[k] != 8'hFF)) r_drop_cnt[k] <= r_drop_cnt[k] + 8'd1;
      end
    end
  end

  always_comb begin
    o_drop_cnt = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) o_drop_cnt[k*8 +: 8] = r_drop_cnt[k];
  end
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb with a simple uart_top busy model.
module tb_uart_tx_arb;

  localparam int PRINT_LEN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_stb;
  logic [63:0] req_data;
  logic [7:0]  req_reg;
  logic [3:0]  req_pend;
  logic [3:0]  req_drop;
  logic [15:0] tx_data;
  logic [1:0]  tx_reg;
  logic        tx_stb;
  logic        tx_busy = 1'b0;
  logic [1:0]  grant;
`ifdef UART_TX_ARB_DROP_CNT_EN
  logic [31:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  int stb_busy_viol = 0;

  typedef struct packed {
    logic [1:0]  grant;
    logic [15:0] data;
    logic [1:0]  tag;
  } log_t;
  log_t tx_log[$];

  uart_tx_arb dut (
    .clk        (clk),
    .rst        (rst),
    .i_req_stb  (req_stb),
    .i_req_data (req_data),
    .i_req_reg  (req_reg),
    .o_req_pend (req_pend),
    .o_req_drop (req_drop),
    .o_tx_data  (tx_data),
    .o_tx_reg   (tx_reg),
    .o_tx_stb   (tx_stb),
    .i_tx_busy  (tx_busy),
`ifdef UART_TX_ARB_DROP_CNT_EN
    .o_drop_cnt (drop_cnt),
`endif
    .o_grant    (grant)
  );

  always #5 clk = ~clk;

  // uart_top stand-in: busy rises the cycle after the strobe and lasts PRINT_LEN cycles.
  always @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_stb) begin
      tx_log.push_back('{grant: grant, data: tx_data, tag: tx_reg});
      if (tx_busy) stb_busy_viol <= stb_busy_viol + 1;
      tx_busy  <= 1'b1;
      busy_cnt <= PRINT_LEN;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic [15:0] d, input logic [1:0] r);
    req_stb[k]          = 1'b1;
    req_data[k*16 +: 16] = d;
    req_reg[k*2 +: 2]   = r;
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int quiet = 0;
    bit ok    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!tx_busy && req_pend == 4'b0 && !tx_stb) quiet++;
      else quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, " quiet"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit held_ok;
    bit fell;
    bit got_busy;
    req_stb  = '0;
    req_data = '0;
    req_reg  = '0;
    rst      = 1'b1;
    repeat (3) tick();
    check_eq("rst pend",  32'(req_pend), 32'd0);
    check_eq("rst drop",  32'(req_drop), 32'd0);
    check_eq("rst stb",   32'(tx_stb),   32'd0);
    check_eq("rst data",  32'(tx_data),  32'd0);
    check_eq("rst reg",   32'(tx_reg),   32'd0);
    check_eq("rst grant", 32'(grant),    32'd0);
    rst = 1'b0;
    repeat (6) tick();

    // Single request, strobe -> o_tx_stb two cycles later.
    req(2, 16'h1234, 2'd3);
    tick();
    req_stb = '0;
    check_eq("t1 pend set",  32'(req_pend[2]), 32'd1);
    check_eq("t1 stb early", 32'(tx_stb),      32'd0);
    tick();
    check_eq("t1 stb",   32'(tx_stb),  32'd1);
    check_eq("t1 data",  32'(tx_data), 32'h1234);
    check_eq("t1 reg",   32'(tx_reg),  32'd3);
    check_eq("t1 grant", 32'(grant),   32'd2);
    tick();
    check_eq("t1 pend clr", 32'(req_pend[2]), 32'd0);
    held_ok = 1'b1;
    fell    = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (tx_reg !== 2'd3 || grant !== 2'd2 || tx_data !== 16'h1234) held_ok = 1'b0;
      if (!tx_busy) begin
        fell = 1'b1;
        break;
      end
      tick();
    end
    check_eq("t1 reg held", 32'(held_ok), 32'd1);
    check_eq("t1 busy fell", 32'(fell), 32'd1);
    wait_quiet(50, "t1");

    // Overflow on requester 0; rr_ptr moves to 1 afterwards.
    tx_log.delete();
    req(0, 16'h0001, 2'd0);
    tick();
    req(0, 16'h0002, 2'd1);
    tick();
    req_stb = '0;
    check_eq("t3 drop pulse", 32'(req_drop), 32'h1);
    check_eq("t3 stb",        32'(tx_stb),   32'd1);
    check_eq("t3 data",       32'(tx_data),  32'h0001);
`ifdef UART_TX_ARB_DROP_CNT_EN
    check_eq("t3 drop cnt",   32'(drop_cnt[7:0]), 32'd1);
`endif
    tick();
    check_eq("t3 drop once", 32'(req_drop), 32'd0);
    wait_quiet(60, "t3");
    check_eq("t3 prints", 32'(tx_log.size()), 32'd1);
    check_eq("t3 sent",   32'(tx_log[0].data), 32'h0001);

    // All four at once with rr_ptr=1: order 1,2,3,0.
    tx_log.delete();
    for (int k = 0; k < 4; k++) req(k, 16'hA000 + 16'(k), 2'(k));
    tick();
    req_stb = '0;
    wait_quiet(200, "t2");
    check_eq("t2 prints", 32'(tx_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2 grant%0d", i), 32'(tx_log[i].grant), 32'((i + 1) % 4));
      check_eq($sformatf("t2 data%0d", i),  32'(tx_log[i].data),  32'hA000 + 32'((i + 1) % 4));
    end
    check_eq("t2 stb vs busy", 32'(stb_busy_viol), 32'd0);

    // Re-arm in own ISSUE cycle.
    tx_log.delete();
    req(1, 16'hBEEF, 2'd1);
    tick();
    req_stb = '0;
    tick();
    check_eq("t4 stb",   32'(tx_stb), 32'd1);
    check_eq("t4 grant", 32'(grant),  32'd1);
    req(1, 16'hBEEF, 2'd1);
    tick();
    req_stb = '0;
    check_eq("t4 no drop", 32'(req_drop),    32'd0);
    check_eq("t4 pend",    32'(req_pend[1]), 32'd1);
    wait_quiet(100, "t4");
    check_eq("t4 prints", 32'(tx_log.size()), 32'd2);
    check_eq("t4 data2",  32'(tx_log[1].data), 32'hBEEF);
    check_eq("t4 grant2", 32'(tx_log[1].grant), 32'd1);

    // Reset mid-print, then confirm rr_ptr restarted at 0.
    req(2, 16'h5555, 2'd2);
    tick();
    req_stb  = '0;
    got_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_busy) begin
        got_busy = 1'b1;
        break;
      end
    end
    check_eq("t5 busy seen", 32'(got_busy), 32'd1);
    tick();
    tick();
    req(1, 16'h1111, 2'd1);
    req(3, 16'h3333, 2'd3);
    tick();
    req_stb = '0;
    check_eq("t5 pend pre", 32'(req_pend), 32'hA);
    rst = 1'b1;
    tick();
    check_eq("t5 pend",  32'(req_pend), 32'd0);
    check_eq("t5 stb",   32'(tx_stb),   32'd0);
    check_eq("t5 grant", 32'(grant),    32'd0);
    check_eq("t5 data",  32'(tx_data),  32'd0);
    rst = 1'b0;
    tick();
    tx_log.delete();
    req(0, 16'h0C0C, 2'd0);
    req(3, 16'h3C3C, 2'd3);
    tick();
    req_stb = '0;
    tick();
    check_eq("t5 idle stb",  32'(tx_stb),  32'd1);
    check_eq("t5 rr grant",  32'(grant),   32'd0);
    check_eq("t5 rr data",   32'(tx_data), 32'h0C0C);
    wait_quiet(100, "t5");
    check_eq("t5 prints", 32'(tx_log.size()), 32'd2);
    check_eq("t5 second", 32'(tx_log[1].grant), 32'd3);

`ifdef UART_TX_ARB_DROP_CNT_EN
    // Saturation: continuous strobes on requester 3.
    check_eq("t6 cnt cleared", drop_cnt, 32'd0);
    for (int i = 0; i < 320; i++) begin
      req(3, 16'h3333, 2'd3);
      tick();
    end
    req_stb = '0;
    check_eq("t6 cnt sat",   32'(drop_cnt[31:24]), 32'hFF);
    check_eq("t6 cnt other", 32'(drop_cnt[23:0]),  32'd0);
    wait_quiet(100, "t6");
    check_eq("t6 cnt hold",  32'(drop_cnt[31:24]), 32'hFF);
`endif

    check_eq("final stb vs busy", 32'(stb_busy_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
